// File: rtl/data_mem_ctrl_if.sv
// CPU load/store bus between the load/store stage and data_mem_ctrl.
// The CPU side drives requests; the memory returns data, valid and busy.
interface data_mem_ctrl_if;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        ld_unsigned;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        rvalid;
    logic        busy;

    modport master (
        output mem_read, mem_write, size, ld_unsigned, addr, din,
        input  dout, rvalid, busy
    );

    modport slave (
        input  mem_read, mem_write, size, ld_unsigned, addr, din,
        output dout, rvalid, busy
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte/half/word data memory with registered loads and a UART upload mode.
// Optional misaligned-access trap: define DMEM_MISALIGN_TRAP_EN.
module data_mem_ctrl #(
    parameter int    ADDR_W    = 14,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    data_mem_ctrl_if.slave    bus,
    input  logic              upg_active_i,
    input  logic              upg_wen_i,
    input  logic [ADDR_W-1:0] upg_adr_i,
    input  logic [31:0]       upg_dat_i,
    input  logic              upg_done_i,
    output logic [ADDR_W:0]   upg_count
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    output logic              misalign
`endif
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_MAX = 1'b1 << ADDR_W;

    typedef enum logic {RUN, UPLOAD} mode_e;

    mode_e             state_q, state_d;
    logic [31:0]       mem_q [DEPTH];
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [31:0]       rword_q;
    logic [1:0]        rlane_q;
    logic [1:0]        rsize_q;
    logic              runs_q;
    logic              rvalid_q;

    logic [ADDR_W-1:0] widx;
    logic [1:0]        lane;
    logic [1:0]        lane_al;
    logic              run;
    logic              bad;
    logic              st_en;
    logic              ld_en;
    logic              go_upl;
    logic              upl_wr;
    logic [3:0]        be;
    logic [31:0]       wdat;
    logic [7:0]        b8;
    logic [15:0]       h16;
    logic [31:0]       ext;
    logic              unused_hi;

    assign widx      = bus.addr[ADDR_W+1:2];
    assign lane      = bus.addr[1:0];
    assign unused_hi = ^bus.addr[31:ADDR_W+2];
    assign run       = (state_q == RUN);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign bad = ((bus.size == 2'b01) && lane[0]) ||
                 (bus.size[1] && (lane != 2'b00));
`else
    assign bad = 1'b0;
`endif

    assign st_en  = run & bus.mem_write & ~bad;
    assign ld_en  = run & bus.mem_read & ~bus.mem_write & ~bad;
    assign go_upl = run & upg_active_i & ~upg_done_i;
    // The upload write on the entry edge is honoured alongside any CPU access.
    assign upl_wr = upg_wen_i & (~run | go_upl);

    always_comb begin
        be      = 4'b1111;
        wdat    = bus.din;
        lane_al = 2'b00;
        unique case (bus.size)
            2'b00: begin
                be      = 4'b0001 << lane;
                wdat    = {4{bus.din[7:0]}};
                lane_al = lane;
            end
            2'b01: begin
                be      = lane[1] ? 4'b1100 : 4'b0011;
                wdat    = {2{bus.din[15:0]}};
                lane_al = {lane[1], 1'b0};
            end
            default: begin
                be      = 4'b1111;
                lane_al = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (st_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[widx][8*b +: 8] <= wdat[8*b +: 8];
            end
        end
        if (upl_wr) mem_q[upg_adr_i] <= upg_dat_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rword_q  <= '0;
            rlane_q  <= 2'b00;
            rsize_q  <= 2'b10;
            runs_q   <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= ld_en;
            if (ld_en) begin
                rword_q <= mem_q[widx];
                rlane_q <= lane_al;
                rsize_q <= bus.size;
                runs_q  <= bus.ld_unsigned;
            end
        end
    end

    assign b8  = rword_q[{rlane_q, 3'b000} +: 8];
    assign h16 = rword_q[{rlane_q[1], 4'b0000} +: 16];

    always_comb begin
        ext = rword_q;
        unique case (rsize_q)
            2'b00:   ext = runs_q ? {24'b0, b8} : {{24{b8[7]}}, b8};
            2'b01:   ext = runs_q ? {16'b0, h16} : {{16{h16[15]}}, h16};
            default: ext = rword_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (upg_active_i && !upg_done_i) state_d = UPLOAD;
            UPLOAD:  if (upg_done_i) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (go_upl) begin
            cnt_d = upl_wr ? {{ADDR_W{1'b0}}, 1'b1} : '0;
        end else if (upl_wr && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic mis_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mis_q <= 1'b0;
        else     mis_q <= run & (bus.mem_read | bus.mem_write) & bad;
    end
    assign misalign = mis_q;
`endif

    assign bus.dout   = ext;
    assign bus.rvalid = rvalid_q;
    assign bus.busy   = (state_q == UPLOAD);
    assign upg_count  = cnt_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized bench for data_mem_ctrl against a byte-array memory model.
// Builds with or without DMEM_MISALIGN_TRAP_EN.
module tb_data_mem_ctrl;
    localparam int AW = 6;
    localparam int NB = 4 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          upg_active_i;
    logic          upg_wen_i;
    logic [AW-1:0] upg_adr_i;
    logic [31:0]   upg_dat_i;
    logic          upg_done_i;
    logic [AW:0]   upg_count;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic          misalign;
`endif

    data_mem_ctrl_if bus();

    data_mem_ctrl #(.ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .upg_active_i (upg_active_i),
        .upg_wen_i    (upg_wen_i),
        .upg_adr_i    (upg_adr_i),
        .upg_dat_i    (upg_dat_i),
        .upg_done_i   (upg_done_i),
        .upg_count    (upg_count)
`ifdef DMEM_MISALIGN_TRAP_EN
        ,
        .misalign     (misalign)
`endif
    );

    always #5 clk = ~clk;

    byte unsigned bm [NB];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.size        = 2'b10;
        bus.ld_unsigned = 1'b0;
        bus.addr        = '0;
        bus.din         = '0;
        upg_wen_i       = 1'b0;
        upg_adr_i       = '0;
        upg_dat_i       = '0;
    endtask

    function automatic int nbytes(logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit misal(logic [31:0] a, logic [1:0] sz);
`ifdef DMEM_MISALIGN_TRAP_EN
        return (a % nbytes(sz)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int base(logic [31:0] a, logic [1:0] sz);
        int b;
        b = int'(a % NB);
        return b - (b % nbytes(sz));
    endfunction

    function automatic logic [31:0] mload(logic [31:0] a, logic [1:0] sz,
                                          logic uns);
        logic [31:0] v;
        int n, b;
        n = nbytes(sz);
        b = base(a, sz);
        v = 0;
        for (int i = 0; i < n; i++) v |= 32'(bm[b+i]) << (8*i);
        if (!uns && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8*n)) - 1);
        return v;
    endfunction

    task automatic mstore(logic [31:0] a, logic [31:0] d, logic [1:0] sz);
        int b;
        b = base(a, sz);
        for (int i = 0; i < nbytes(sz); i++) bm[b+i] = 8'(d >> (8*i));
    endtask

    task automatic mword(int w, logic [31:0] d);
        for (int i = 0; i < 4; i++) bm[4*(w % (NB/4))+i] = 8'(d >> (8*i));
    endtask

    task automatic do_store(logic [31:0] a, logic [31:0] d, logic [1:0] sz);
        bit m;
        m = misal(a, sz);
        bus.addr = a; bus.din = d; bus.size = sz; bus.mem_write = 1'b1;
        step();
        idle();
        if (!m) mstore(a, d, sz);
        check("st_rvalid", bus.rvalid, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("st_misalign", misalign, m);
`endif
    endtask

    task automatic do_load(logic [31:0] a, logic [1:0] sz, logic uns);
        logic [31:0] e;
        bit m;
        e = mload(a, sz, uns);
        m = misal(a, sz);
        bus.addr = a; bus.size = sz; bus.ld_unsigned = uns;
        bus.mem_read = 1'b1;
        step();
        idle();
`ifdef DMEM_MISALIGN_TRAP_EN
        check("ld_misalign", misalign, m);
`endif
        if (m) begin
            check("ld_mis_rvalid", bus.rvalid, 0);
        end else begin
            check("ld_rvalid", bus.rvalid, 1);
            check("ld_dout", bus.dout, e);
        end
        step();
        check("ld_pulse", bus.rvalid, 0);
        if (!m) check("ld_hold", bus.dout, e);
    endtask

    task automatic do_both(logic [31:0] a, logic [31:0] d, logic [1:0] sz);
        bit m;
        m = misal(a, sz);
        bus.addr = a; bus.din = d; bus.size = sz;
        bus.mem_read = 1'b1; bus.mem_write = 1'b1;
        step();
        idle();
        if (!m) mstore(a, d, sz);
        check("both_rvalid", bus.rvalid, 0);
    endtask

    task automatic upl_write(int w, logic [31:0] d);
        upg_wen_i = 1'b1; upg_adr_i = AW'(w); upg_dat_i = d;
        step();
        upg_wen_i = 1'b0;
        mword(w, d);
    endtask

    initial begin
        logic [31:0] v;
        int op;
        idle();
        upg_active_i = 1'b0;
        upg_done_i   = 1'b0;
        rst = 1'b1;
        step();
        step();
        check("rst_dout", bus.dout, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_count", upg_count, 0);
        rst = 1'b0;
        step();

        // Fill the whole array by upload, overrunning the depth.
        upg_active_i = 1'b1;
        step();
        check("upl_busy", bus.busy, 1);
        check("upl_cnt0", upg_count, 0);
        for (int i = 0; i < NB/4 + 6; i++) upl_write(i, $urandom);
        check("upl_sat", upg_count, NB/4);
        upg_active_i = 1'b0;
        upg_done_i = 1'b1;
        step();
        upg_done_i = 1'b0;
        check("upl_exit", bus.busy, 0);
        check("upl_cnt_hold", upg_count, NB/4);

        do_store(32'h10, 32'h8000_00F0, 2'b10);
        do_load(32'h10, 2'b10, 1'b0);
        check("tp_lw", bus.dout, 32'h8000_00F0);
        do_store(32'h13, 32'hAB, 2'b00);
        do_load(32'h13, 2'b00, 1'b0);
        check("tp_lb", bus.dout, 32'hFFFF_FFAB);
        do_load(32'h13, 2'b00, 1'b1);
        check("tp_lbu", bus.dout, 32'h0000_00AB);
        do_load(32'h10, 2'b10, 1'b0);
        check("tp_lw2", bus.dout, 32'hAB00_00F0);
        do_store(32'h12, 32'h8001, 2'b01);
        do_load(32'h12, 2'b01, 1'b0);
        check("tp_lh", bus.dout, 32'hFFFF_8001);
        do_load(32'h12, 2'b01, 1'b1);
        check("tp_lhu", bus.dout, 32'h0000_8001);

        upg_active_i = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            upl_write(i, 32'h11 * (i + 1));
            if (i == 1) begin
                bus.addr = 32'h0; bus.din = 32'hDEAD_BEEF;
                bus.mem_write = 1'b1;
                step();
                idle();
                bus.mem_read = 1'b1;
                step();
                idle();
                check("upl_ld_drop", bus.rvalid, 0);
            end
        end
        check("upl_busy2", bus.busy, 1);
        upg_active_i = 1'b0;
        upg_done_i = 1'b1;
        step();
        upg_done_i = 1'b0;
        check("upl_done", bus.busy, 0);
        check("upl_cnt4", upg_count, 4);
        do_load(32'h0, 2'b10, 1'b0);
        check("tp_upl_lw", bus.dout, 32'h11);

        do_both(32'h20, 32'd5, 2'b10);
        do_load(32'h20, 2'b10, 1'b0);
        check("tp_both", bus.dout, 32'd5);
        do_load(32'h22, 2'b10, 1'b0);
`ifndef DMEM_MISALIGN_TRAP_EN
        check("tp_lw22", bus.dout, 32'd5);
`endif

        // Upload strobes in RUN must not touch the array.
        upl_write(5, 32'hCAFE_F00D);
        for (int i = 0; i < 4; i++) bm[20+i] = 8'(32'd0);
        bus.addr = 32'h14;
        step();
        idle();
        do_store(32'h14, 32'd0, 2'b10);
        upl_write(5, 32'hCAFE_F00D);
        mword(5, 32'd0);
        do_load(32'h14, 2'b10, 1'b0);

        upg_active_i = 1'b1;
        upg_done_i = 1'b1;
        step();
        check("act_done_run", bus.busy, 0);
        upg_active_i = 1'b0;
        upg_done_i = 1'b0;

        // Entry cycle: upload write and CPU load both served.
        v = mload(32'h20, 2'b10, 1'b0);
        upg_active_i = 1'b1;
        upg_wen_i = 1'b1; upg_adr_i = AW'(7); upg_dat_i = 32'h1234_5678;
        bus.addr = 32'h20; bus.size = 2'b10; bus.mem_read = 1'b1;
        step();
        idle();
        mword(7, 32'h1234_5678);
        check("entry_busy", bus.busy, 1);
        check("entry_rvalid", bus.rvalid, 1);
        check("entry_dout", bus.dout, v);
        upg_active_i = 1'b0;
        upg_done_i = 1'b1;
        step();
        upg_done_i = 1'b0;
        do_load(32'h1C, 2'b10, 1'b0);

        upg_active_i = 1'b1;
        step();
        upl_write(9, 32'h0BAD_F00D);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_cnt", upg_count, 0);
        upg_active_i = 1'b0;
        step();
        rst = 1'b0;
        step();
        do_load(32'h24, 2'b10, 1'b0);

        for (int i = 0; i < 400; i++) begin
            op = int'($urandom_range(0, 3));
            unique case (op)
                0: do_store($urandom, $urandom, 2'($urandom));
                3: do_both($urandom, $urandom, 2'($urandom));
                default: do_load($urandom, 2'($urandom), 1'($urandom));
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
